// File: rtl/main_fsm.sv
// main_fsm: multi-cycle control sequencer for the RV32I core.
// Walks each instruction through fetch/decode/execute/memory/writeback
// and drives the datapath mux selects, write enables and ALUOp.
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       Zero,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       PCWrite,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    // Opcodes recognised in DECODE / MEMADR
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    // Per-state control word; PCUpdate and Branch only feed PCWrite
    typedef struct packed {
        logic [1:0] aluop;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] rsrc;
        logic       adrsrc;
        logic       irwrite;
        logic       regwrite;
        logic       memwrite;
        logic       pcupdate;
        logic       branch;
    } ctl_t;

    state_t state_q;
    ctl_t   ctl_q;

    // Next-state function of the current state and opcode
    function automatic state_t next_state(input state_t s, input logic [6:0] opc);
        state_t n;
        n = FETCH;
        case (s)
            FETCH:    n = DECODE;
            DECODE: begin
                case (opc)
                    OP_LW, OP_SW: n = MEMADR;
                    OP_RTYPE:     n = EXECUTER;
                    OP_ITYPE:     n = EXECUTEI;
                    OP_JAL:       n = JAL;
                    OP_BEQ:       n = BEQ;
                    default:      n = FETCH;
                endcase
            end
            MEMADR:   n = (opc == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  n = MEMWB;
            MEMWB:    n = FETCH;
            MEMWRITE: n = FETCH;
            EXECUTER: n = ALUWB;
            EXECUTEI: n = ALUWB;
            JAL:      n = ALUWB;
            ALUWB:    n = FETCH;
            BEQ:      n = FETCH;
            default:  n = FETCH;
        endcase
        return n;
    endfunction

    // Moore output decode; unlisted outputs and unused codes give all zeros
    function automatic ctl_t decode_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite  = 1'b1;
                c.srcb     = 2'b10;
                c.rsrc     = 2'b10;
                c.pcupdate = 1'b1;
            end
            DECODE: begin
                c.srca = 2'b01;
                c.srcb = 2'b01;
            end
            MEMADR: begin
                c.srca = 2'b10;
                c.srcb = 2'b01;
            end
            MEMREAD: begin
                c.adrsrc = 1'b1;
            end
            MEMWB: begin
                c.rsrc     = 2'b01;
                c.regwrite = 1'b1;
            end
            MEMWRITE: begin
                c.adrsrc   = 1'b1;
                c.memwrite = 1'b1;
            end
            EXECUTER: begin
                c.srca  = 2'b10;
                c.aluop = 2'b10;
            end
            EXECUTEI: begin
                c.srca  = 2'b10;
                c.srcb  = 2'b01;
                c.aluop = 2'b10;
            end
            ALUWB: begin
                c.regwrite = 1'b1;
            end
            BEQ: begin
                c.srca   = 2'b10;
                c.aluop  = 2'b01;
                c.branch = 1'b1;
            end
            JAL: begin
                c.srca     = 2'b01;
                c.srcb     = 2'b10;
                c.pcupdate = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // State register with outputs registered alongside it: the control
    // word is decoded from the next state so it always matches state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            ctl_q   <= decode_ctl(FETCH);
        end else begin
            state_q <= next_state(state_q, op);
            ctl_q   <= decode_ctl(next_state(state_q, op));
        end
    end

    // Drive ports from the registered control word
    always_comb begin
        ALUOp     = ctl_q.aluop;
        ALUSrcA   = ctl_q.srca;
        ALUSrcB   = ctl_q.srcb;
        ResultSrc = ctl_q.rsrc;
        AdrSrc    = ctl_q.adrsrc;
        IRWrite   = ctl_q.irwrite;
        RegWrite  = ctl_q.regwrite;
        MemWrite  = ctl_q.memwrite;
        PCWrite   = ctl_q.pcupdate | (ctl_q.branch & Zero);
        state     = state_q;
    end

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: directed-vector bench for the multi-cycle control FSM.
module tb_main_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       Zero;
    logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc, IRWrite, RegWrite, MemWrite, PCWrite;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    int rw_cnt = 0;
    int mw_cnt = 0;

    main_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .Zero      (Zero),
        .ALUOp     (ALUOp),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .AdrSrc    (AdrSrc),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .PCWrite   (PCWrite),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count write-enable pulses as seen by the datapath on each edge
    always @(posedge clk) begin
        if (RegWrite) rw_cnt++;
        if (MemWrite) mw_cnt++;
    end

    // Control word: {ALUOp,ALUSrcA,ALUSrcB,ResultSrc,AdrSrc,IRWrite,RegWrite,MemWrite,PCWrite}
    localparam logic [12:0] C_FETCH  = 13'b00_00_10_10_0_1_0_0_1;
    localparam logic [12:0] C_DECODE = 13'b00_01_01_00_0_0_0_0_0;
    localparam logic [12:0] C_MEMADR = 13'b00_10_01_00_0_0_0_0_0;
    localparam logic [12:0] C_MEMRD  = 13'b00_00_00_00_1_0_0_0_0;
    localparam logic [12:0] C_MEMWB  = 13'b00_00_00_01_0_0_1_0_0;
    localparam logic [12:0] C_MEMWR  = 13'b00_00_00_00_1_0_0_1_0;
    localparam logic [12:0] C_EXER   = 13'b10_10_00_00_0_0_0_0_0;
    localparam logic [12:0] C_ALUWB  = 13'b00_00_00_00_0_0_1_0_0;
    localparam logic [12:0] C_EXEI   = 13'b10_10_01_00_0_0_0_0_0;
    localparam logic [12:0] C_JAL    = 13'b00_01_10_00_0_0_0_0_1;
    localparam logic [12:0] C_BEQ0   = 13'b01_10_00_00_0_0_0_0_0;
    localparam logic [12:0] C_BEQ1   = 13'b01_10_00_00_0_0_0_0_1;

    function automatic logic [12:0] ctl_now();
        return {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, RegWrite, MemWrite, PCWrite};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and check state and control word 2ns after the edge
    task automatic step(input string tag, input logic [3:0] exp_state, input logic [12:0] exp_ctl);
        @(posedge clk);
        #2;
        check({tag, ".state"}, {28'd0, state}, {28'd0, exp_state});
        check({tag, ".ctl"}, {19'd0, ctl_now()}, {19'd0, exp_ctl});
    endtask

    int rw0, mw0;

    initial begin
        reset = 1'b1;
        op    = 7'd0;
        Zero  = 1'b0;

        // Reset held for 3 cycles
        #2;
        check("rst.state", {28'd0, state}, 32'd0);
        check("rst.ctl", {19'd0, ctl_now()}, {19'd0, C_FETCH});
        repeat (3) @(posedge clk);
        #2;
        check("rst3.state", {28'd0, state}, 32'd0);
        reset = 1'b0;

        // lw: 0,1,2,3,4,0
        op = 7'b0000011;
        rw0 = rw_cnt; mw0 = mw_cnt;
        step("lw1", 4'd1, C_DECODE);
        step("lw2", 4'd2, C_MEMADR);
        step("lw3", 4'd3, C_MEMRD);
        step("lw4", 4'd4, C_MEMWB);
        step("lw0", 4'd0, C_FETCH);
        check("lw.rw_pulses", rw_cnt - rw0, 32'd1);
        check("lw.mw_pulses", mw_cnt - mw0, 32'd0);

        // sw: 0,1,2,5,0
        op = 7'b0100011;
        rw0 = rw_cnt; mw0 = mw_cnt;
        step("sw1", 4'd1, C_DECODE);
        step("sw2", 4'd2, C_MEMADR);
        step("sw5", 4'd5, C_MEMWR);
        step("sw0", 4'd0, C_FETCH);
        check("sw.mw_pulses", mw_cnt - mw0, 32'd1);
        check("sw.rw_pulses", rw_cnt - rw0, 32'd0);

        // R-type: 0,1,6,7,0
        op = 7'b0110011;
        step("r1", 4'd1, C_DECODE);
        step("r6", 4'd6, C_EXER);
        step("r7", 4'd7, C_ALUWB);
        step("r0", 4'd0, C_FETCH);

        // addi: 0,1,8,7,0
        op = 7'b0010011;
        step("i1", 4'd1, C_DECODE);
        step("i8", 4'd8, C_EXEI);
        step("i7", 4'd7, C_ALUWB);
        step("i0", 4'd0, C_FETCH);

        // beq taken, with PCWrite following Zero inside the state
        op = 7'b1100011;
        Zero = 1'b1;
        step("beqT1", 4'd1, C_DECODE);
        step("beqT10", 4'd10, C_BEQ1);
        Zero = 1'b0;
        #1;
        check("beq.zero_drop.pcw", {31'd0, PCWrite}, 32'd0);
        Zero = 1'b1;
        #1;
        check("beq.zero_rise.pcw", {31'd0, PCWrite}, 32'd1);
        step("beqT0", 4'd0, C_FETCH);

        // beq not taken
        Zero = 1'b0;
        step("beqN1", 4'd1, C_DECODE);
        step("beqN10", 4'd10, C_BEQ0);
        step("beqN0", 4'd0, C_FETCH);

        // jal: 0,1,9,7,0
        op = 7'b1101111;
        step("jal1", 4'd1, C_DECODE);
        step("jal9", 4'd9, C_JAL);
        step("jal7", 4'd7, C_ALUWB);
        step("jal0", 4'd0, C_FETCH);

        // illegal opcode: 0,1,0 with no writes
        op = 7'b1111111;
        rw0 = rw_cnt; mw0 = mw_cnt;
        step("ill1", 4'd1, C_DECODE);
        step("ill0", 4'd0, C_FETCH);
        check("ill.rw_pulses", rw_cnt - rw0, 32'd0);
        check("ill.mw_pulses", mw_cnt - mw0, 32'd0);

        // lw aborted by reset in MEMREAD
        op = 7'b0000011;
        step("ab1", 4'd1, C_DECODE);
        step("ab2", 4'd2, C_MEMADR);
        step("ab3", 4'd3, C_MEMRD);
        rw0 = rw_cnt; mw0 = mw_cnt;
        reset = 1'b1;
        #1;
        check("abort.state", {28'd0, state}, 32'd0);
        check("abort.ctl", {19'd0, ctl_now()}, {19'd0, C_FETCH});
        repeat (2) @(posedge clk);
        #2;
        check("abort.hold.state", {28'd0, state}, 32'd0);
        check("abort.rw_pulses", rw_cnt - rw0, 32'd0);
        reset = 1'b0;
        step("post1", 4'd1, C_DECODE);
        check("abort.mw_pulses", mw_cnt - mw0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
